// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences MEM-stage loads/stores onto an SRAM-like data bus,
// formats store lanes, extends load results, flags misalignment and absorbs
// responses that belong to flushed accesses.
module mem_access_ctrl #(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_wr,
    input  logic [1:0]  mem_length,
    input  logic        mem_signed,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        pipe_advance,
    input  logic        flush,
    output logic        mem_stall,
    output logic [31:0] load_data,
    output logic        adel,
    output logic        ades,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

    state_t      state, next_state;
    logic        mis, accept;
    logic        sgn_q;
    logic [1:0]  len_q;
    logic [1:0]  fmt_size;
    logic [31:0] fmt_wdata;
    logic [3:0]  fmt_wstrb;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] ext_data;

    // Misalignment check and request acceptance, both combinational on MEM inputs
    always_comb begin
        mis    = CHECK_ALIGN && ((mem_length == 2'b01 && mem_addr[0]) ||
                                 (mem_length[1] && mem_addr[1:0] != 2'b00));
        adel   = mem_en & ~mem_wr & mis;
        ades   = mem_en & mem_wr & mis;
        accept = (state == IDLE) & mem_en & ~mis & ~flush;
        mem_stall = accept | (state == REQ) | (state == WAIT) | (state == DRAIN);
    end

    // Store lane replication and byte enables; loads carry no strobes
    always_comb begin
        fmt_size  = mem_length[1] ? 2'd2 : {1'b0, mem_length[0]};
        fmt_wdata = mem_length[1] ? mem_wdata :
                    mem_length[0] ? {2{mem_wdata[15:0]}} : {4{mem_wdata[7:0]}};
        fmt_wstrb = ~mem_wr       ? 4'b0000 :
                    mem_length[1] ? 4'b1111 :
                    mem_length[0] ? 4'b0011 << {mem_addr[1], 1'b0} :
                                    4'b0001 << mem_addr[1:0];
    end

    // Load lane selection and extension using the latched address/length/sign
    always_comb begin
        byte_lane = data_addr[1] ? (data_addr[0] ? data_rdata[31:24] : data_rdata[23:16])
                                 : (data_addr[0] ? data_rdata[15:8]  : data_rdata[7:0]);
        half_lane = data_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
        ext_data  = len_q[1] ? data_rdata :
                    len_q[0] ? {{16{sgn_q & half_lane[15]}}, half_lane} :
                               {{24{sgn_q & byte_lane[7]}}, byte_lane};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic; a flush either drops, drains or discards the access in flight
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = accept ? REQ : IDLE;
            REQ:     next_state = flush ? (data_addr_ok ? DRAIN : IDLE) :
                                  data_addr_ok ? WAIT : REQ;
            WAIT:    next_state = flush ? (data_data_ok ? IDLE : DRAIN) :
                                  data_data_ok ? DONE : WAIT;
            DONE:    next_state = (pipe_advance | flush) ? IDLE : DONE;
            DRAIN:   next_state = data_data_ok ? IDLE : DRAIN;
            default: next_state = IDLE;
        endcase
    end

    // Bus fields latched on acceptance and held until the next one; result captured on data_ok
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= 2'd0;
            data_addr  <= 32'd0;
            data_wdata <= 32'd0;
            data_wstrb <= 4'd0;
            load_data  <= 32'd0;
            len_q      <= 2'd0;
            sgn_q      <= 1'b0;
        end else begin
            data_req <= (next_state == REQ);
            if (accept) begin
                data_wr    <= mem_wr;
                data_size  <= fmt_size;
                data_addr  <= mem_addr;
                data_wdata <= fmt_wdata;
                data_wstrb <= fmt_wstrb;
                len_q      <= mem_length;
                sgn_q      <= mem_signed;
            end
            if (state == WAIT && data_data_ok && !flush) load_data <= ext_data;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized checks of mem_access_ctrl against an arithmetic model
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_en = 1'b0, mem_wr = 1'b0, mem_signed = 1'b0;
    logic [1:0]  mem_length = 2'd0;
    logic [31:0] mem_addr = 32'd0, mem_wdata = 32'd0;
    logic        pipe_advance = 1'b0, flush = 1'b0;
    logic        mem_stall, adel, ades, data_req, data_wr;
    logic [31:0] load_data, data_addr, data_wdata;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
    logic [31:0] data_rdata = 32'd0;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] last_load = 32'd0;

    mem_access_ctrl dut (
        .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wr(mem_wr), .mem_length(mem_length),
        .mem_signed(mem_signed), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .pipe_advance(pipe_advance), .flush(flush), .mem_stall(mem_stall),
        .load_data(load_data), .adel(adel), .ades(ades), .data_req(data_req),
        .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int nbytes(input logic [1:0] len);
        return len[1] ? 4 : len[0] ? 2 : 1;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [1:0] len,
                                             input logic sgn, input logic [1:0] off);
        int nb;
        logic [31:0] mask, v;
        nb = nbytes(len);
        mask = (nb == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nb)) - 32'h1;
        v = (rd >> (8 * int'(off))) & mask;
        if (sgn && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] exp_strb(input logic wr, input logic [1:0] len, input logic [1:0] off);
        logic [3:0] s;
        s = 4'b0000;
        for (int i = 0; i < 4; i++)
            s[i] = wr && i >= int'(off) && i < int'(off) + nbytes(len);
        return s;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input logic [1:0] len);
        logic [31:0] w;
        w = 32'd0;
        for (int i = 0; i < 4; i++) w[8 * i +: 8] = wd[8 * (i % nbytes(len)) +: 8];
        return w;
    endfunction

    // One complete aligned access; called with the DUT idle just after a clock edge
    task automatic do_access(input logic wr, input logic [1:0] len, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rd, input int aw, input int dw);
        logic [1:0] sz;
        sz = len[1] ? 2'd2 : {1'b0, len[0]};
        mem_en = 1'b1; mem_wr = wr; mem_length = len; mem_signed = sgn;
        mem_addr = addr; mem_wdata = wd;
        #1;
        check("stall_on_accept", mem_stall, 1);
        check("no_adel", adel, 0);
        check("no_ades", ades, 0);
        tick();
        for (int i = 0; i < aw; i++) begin
            check("req_held", data_req, 1);
            check("addr_held", data_addr, addr);
            check("size_held", data_size, sz);
            check("stall_req", mem_stall, 1);
            tick();
        end
        check("req", data_req, 1);
        check("wr", data_wr, wr);
        check("size", data_size, sz);
        check("addr", data_addr, addr);
        check("wstrb", data_wstrb, exp_strb(wr, len, addr[1:0]));
        if (wr) check("wdata", data_wdata, exp_wdata(wd, len));
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        check("req_dropped", data_req, 0);
        for (int i = 0; i < dw; i++) begin
            check("stall_wait", mem_stall, 1);
            tick();
        end
        data_data_ok = 1'b1; data_rdata = rd;
        tick();
        data_data_ok = 1'b0; data_rdata = $urandom;
        #1;
        check("done_no_stall", mem_stall, 0);
        if (!wr) begin
            last_load = exp_load(rd, len, sgn, addr[1:0]);
            check("load_data", load_data, last_load);
        end
        pipe_advance = 1'b1;
        tick();
        pipe_advance = 1'b0; mem_en = 1'b0;
    endtask

    initial begin
        logic [1:0]  len;
        logic [31:0] a;
        // Reset state
        tick(); tick();
        check("rst_req", data_req, 0);
        check("rst_wr", data_wr, 0);
        check("rst_size", data_size, 0);
        check("rst_addr", data_addr, 0);
        check("rst_wdata", data_wdata, 0);
        check("rst_wstrb", data_wstrb, 0);
        check("rst_load", load_data, 0);
        check("rst_stall", mem_stall, 0);
        rst = 1'b0;
        tick();

        // Byte loads from lane 3, signed then unsigned
        do_access(1'b0, 2'b00, 1'b1, 32'h1000_0003, 32'd0, 32'h80FF_0000, 0, 0);
        check("lb_signed", load_data, 32'hFFFF_FF80);
        do_access(1'b0, 2'b00, 1'b0, 32'h1000_0003, 32'd0, 32'h80FF_0000, 1, 1);
        check("lb_unsigned", load_data, 32'h0000_0080);

        // Halfword store to upper lane
        do_access(1'b1, 2'b01, 1'b0, 32'h1000_0002, 32'h0000_BEEF, 32'd0, 0, 0);
        check("sh_wdata", data_wdata, 32'hBEEF_BEEF);
        check("sh_wstrb", data_wstrb, 4'b1100);
        check("sh_size", data_size, 1);
        check("sh_req_low", data_req, 0);

        // Misaligned word load and store
        mem_en = 1'b1; mem_wr = 1'b0; mem_length = 2'b10; mem_addr = 32'h1000_0002;
        #1;
        check("lw_adel", adel, 1);
        check("lw_ades", ades, 0);
        check("lw_mis_stall", mem_stall, 0);
        tick();
        check("lw_mis_req", data_req, 0);
        mem_wr = 1'b1;
        #1;
        check("sw_ades", ades, 1);
        check("sw_adel", adel, 0);
        check("sw_mis_stall", mem_stall, 0);
        tick();
        check("sw_mis_req", data_req, 0);
        mem_en = 1'b0;
        tick();

        // Request held for five cycles without addr_ok
        do_access(1'b0, 2'b11, 1'b0, 32'h1000_0010, 32'd0, 32'hCAFE_F00D, 5, 0);

        // Flush while waiting for data: response drained and discarded
        mem_en = 1'b1; mem_wr = 1'b0; mem_length = 2'b10; mem_addr = 32'h2000_0000;
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        flush = 1'b1; mem_en = 1'b0;
        tick();
        flush = 1'b0;
        #1;
        check("drain_stall", mem_stall, 1);
        check("drain_req", data_req, 0);
        tick();
        data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
        #1;
        check("drain_stall2", mem_stall, 1);
        tick();
        data_data_ok = 1'b0;
        #1;
        check("drain_idle_stall", mem_stall, 0);
        check("drain_load_kept", load_data, last_load);

        // Flush coinciding with addr_ok: next access waits for the drain
        mem_en = 1'b1; mem_wr = 1'b0; mem_length = 2'b10; mem_addr = 32'h2000_0004;
        tick();
        data_addr_ok = 1'b1; flush = 1'b1;
        tick();
        data_addr_ok = 1'b0; flush = 1'b0;
        mem_addr = 32'h3000_0000; mem_length = 2'b00;
        #1;
        check("dr2_stall", mem_stall, 1);
        check("dr2_req", data_req, 0);
        tick();
        check("dr2_req_still", data_req, 0);
        data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        tick();
        data_data_ok = 1'b0;
        #1;
        check("dr2_accept_stall", mem_stall, 1);
        check("dr2_req_pre", data_req, 0);
        tick();
        check("dr2_req_new", data_req, 1);
        check("dr2_addr_new", data_addr, 32'h3000_0000);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0000_00A5;
        tick();
        data_data_ok = 1'b0;
        last_load = 32'h0000_00A5;
        check("dr2_load", load_data, last_load);
        pipe_advance = 1'b1; mem_en = 1'b0;
        tick();
        pipe_advance = 1'b0;

        // Reset mid-access, late response ignored
        mem_en = 1'b1; mem_wr = 1'b0; mem_length = 2'b10; mem_addr = 32'h4000_0000;
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; mem_en = 1'b0; rst = 1'b1;
        #1;
        check("mid_rst_req", data_req, 0);
        check("mid_rst_stall", mem_stall, 0);
        check("mid_rst_load", load_data, 0);
        tick();
        rst = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
        tick();
        data_data_ok = 1'b0;
        #1;
        check("late_rsp_stall", mem_stall, 0);
        check("late_rsp_load", load_data, 0);
        tick();

        // Randomized aligned accesses
        for (int n = 0; n < 40; n++) begin
            len = 2'($urandom_range(0, 3));
            a = $urandom;
            if (len[1]) a[1:0] = 2'b00;
            else if (len[0]) a[0] = 1'b0;
            do_access(1'($urandom), len, 1'($urandom), a, $urandom, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Randomized misaligned accesses
        for (int n = 0; n < 10; n++) begin
            mem_en = 1'b1; mem_wr = 1'($urandom);
            mem_length = (n % 2 == 0) ? 2'b01 : 2'b10;
            a = $urandom;
            if (n % 2 == 0) a[0] = 1'b1;
            else a[1:0] = 2'($urandom_range(1, 3));
            mem_addr = a;
            #1;
            check("rnd_adel", adel, !mem_wr);
            check("rnd_ades", ades, mem_wr);
            check("rnd_mis_stall", mem_stall, 0);
            tick();
            check("rnd_mis_req", data_req, 0);
        end
        mem_en = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
